// File: rtl/seq_adder_pkg.sv
// Shared definitions for the sequential chunked adder.
//   state_e      : controller states (idle, slice-add run, result hold)
//   clog2_min1   : index width helper, never returns less than 1
//   params_ok    : legality check on operand/slice widths, used at elaboration
package seq_adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic bit params_ok(input int unsigned width_a, input int unsigned width_b,
                                   input int unsigned chunk);
    return (chunk != 0) && (width_a % chunk == 0) && (width_b <= width_a) && (width_b != 0);
  endfunction

endpackage

// File: rtl/ripple_slice_adder.sv
// CHUNK-bit unsigned ripple-carry adder slice.
//   a, b : slice operands
//   cin  : carry in
//   s    : slice sum
//   cout : carry out of the top bit
module ripple_slice_adder #(
  parameter int unsigned CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[CHUNK];
  end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: sum = a + zero-extended b, one CHUNK-bit slice per clock with the
// carry held in a register between slices. Result valid WIDTH_A/CHUNK cycles after accept.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : operand handshake (accepted only in idle)
//   a, b                : operands, b zero-extended to WIDTH_A
//   sub                 : (SEQ_ADDER_SUB_EN only) compute a - b; sum MSB is no-borrow
//   out_valid/out_ready : result handshake, sum held stable until consumed
//   sum                 : WIDTH_A+1 bit result, MSB is carry-out
//   busy                : operation in progress or result pending
// Optional feature macro: SEQ_ADDER_SUB_EN.
module seq_chunk_adder
  import seq_adder_pkg::*;
#(
  parameter int unsigned WIDTH_A = 64,
  parameter int unsigned WIDTH_B = 5,
  parameter int unsigned CHUNK   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef SEQ_ADDER_SUB_EN
  input  logic               sub,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_A-1:0] a,
  input  logic [WIDTH_B-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_A:0]   sum,
  output logic               busy
);

  localparam int unsigned NCHUNK = WIDTH_A / CHUNK;
  localparam int unsigned IDX_W  = clog2_min1(NCHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if (!params_ok(WIDTH_A, WIDTH_B, CHUNK)) begin : g_bad_params
    $error("seq_chunk_adder: WIDTH_A must be a multiple of CHUNK and WIDTH_B <= WIDTH_A");
  end

  state_e             state_q;
  logic [WIDTH_A-1:0] a_q;
  logic [WIDTH_A-1:0] b_ext_q;
  logic [WIDTH_A:0]   sum_q;
  logic               carry_q;
  logic [IDX_W-1:0]   idx_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  logic [WIDTH_A-1:0] b_ext;
  logic               init_carry;
  int unsigned        base;
  logic [CHUNK-1:0]   a_slice;
  logic [CHUNK-1:0]   b_slice;
  logic [CHUNK-1:0]   s_slice;
  logic               c_out;

  always_comb begin
    b_ext      = WIDTH_A'(b);
    init_carry = 1'b0;
`ifdef SEQ_ADDER_SUB_EN
    // Two's complement subtract: invert the extended operand and inject a carry of one.
    if (sub) begin
      b_ext      = ~WIDTH_A'(b);
      init_carry = 1'b1;
    end
`endif
  end

  assign base    = int'(idx_q) * CHUNK;
  assign a_slice = a_q[base +: CHUNK];
  assign b_slice = b_ext_q[base +: CHUNK];

  ripple_slice_adder #(
    .CHUNK(CHUNK)
  ) u_slice (
    .a   (a_slice),
    .b   (b_slice),
    .cin (carry_q),
    .s   (s_slice),
    .cout(c_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_ext_q     <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q        <= a;
            b_ext_q    <= b_ext;
            carry_q    <= init_carry;
            idx_q      <= '0;
            state_q    <= StRun;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StRun: begin
          sum_q[base +: CHUNK] <= s_slice;
          carry_q              <= c_out;
          if (idx_q == LAST_IDX) begin
            sum_q[WIDTH_A] <= c_out;
            idx_q          <= '0;
            state_q        <= StDone;
            out_valid_q    <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign sum       = sum_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder (default 64/5/16 instance) plus a 32/32/8 instance
// checked against a + b over a batch of random operands.
module tb_seq_chunk_adder;

  logic        clk;
  logic        rst_n;
  logic        sub;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [4:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [64:0] sum;
  logic        busy;

  logic        in_valid32;
  logic        in_ready32;
  logic [31:0] a32;
  logic [31:0] b32;
  logic        out_valid32;
  logic        out_ready32;
  logic [32:0] sum32;
  logic        busy32;

  int n_checks;
  int n_fail;

  seq_chunk_adder #(
    .WIDTH_A(64),
    .WIDTH_B(5),
    .CHUNK  (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef SEQ_ADDER_SUB_EN
    .sub      (sub),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .busy     (busy)
  );

  seq_chunk_adder #(
    .WIDTH_A(32),
    .WIDTH_B(32),
    .CHUNK  (8)
  ) dut32 (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef SEQ_ADDER_SUB_EN
    .sub      (1'b0),
`endif
    .in_valid (in_valid32),
    .in_ready (in_ready32),
    .a        (a32),
    .b        (b32),
    .out_valid(out_valid32),
    .out_ready(out_ready32),
    .sum      (sum32),
    .busy     (busy32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits for in_ready, presents one operand pair, returns cycles from accept to out_valid.
  task automatic do_op(input logic [63:0] av, input logic [4:0] bv, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++;
    if (sum !== 65'h0) begin n_fail++; $display("FAIL reset_sum got %h want 0", sum); end
  endtask

  task automatic test_full_carry();
    int lat;
    fork
      begin
        @(posedge clk); #1;
        if (in_ready) begin
          // Wait until the accept has happened, then look at the first RUN cycle.
          @(posedge clk); #1;
        end
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
          n_fail++; $display("FAIL run_flags busy=%b in_ready=%b want 1 0", busy, in_ready);
        end
      end
    join_none
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 5'd1, lat);
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("FAIL full_carry_latency got %0d want 4", lat); end
    n_checks++;
    if (sum !== 65'h1_0000_0000_0000_0000) begin
      n_fail++; $display("FAIL full_carry_sum got %h want 10000000000000000", sum);
    end
    consume();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL consume_flags in_ready=%b out_valid=%b busy=%b want 1 0 0",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_chunk_boundary();
    int lat;
    do_op(64'h0000_0000_0000_FFF0, 5'h1F, lat);
    n_checks++;
    if (sum !== 65'h0_0000_0000_0001_000F) begin
      n_fail++; $display("FAIL chunk_boundary_sum got %h want 0000000000001000f", sum);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    do_op(64'h1234_5678_9ABC_DEF0, 5'h10, lat);
    bad = 0;
    // A competing request is held up the whole time and must be ignored.
    a = 64'hDEAD_BEEF_0000_0001; b = 5'h3; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (sum !== 65'h0_1234_5678_9ABC_DF00 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_fail++; bad++;
        $display("FAIL backpressure_hold cyc %0d sum=%h in_ready=%b out_valid=%b want %h 0 1",
                 i, sum, in_ready, out_valid, 65'h0_1234_5678_9ABC_DF00);
      end
    end
    in_valid = 1'b0;
    consume();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 5'h1F; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL abort_out_valid got %0d cycles want 0", seen); end
    n_checks++;
    if (sum !== 65'h0) begin n_fail++; $display("FAIL abort_sum got %h want 0", sum); end
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_flags in_ready=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [63:0] av [3];
    logic [4:0]  bv [3];
    logic [64:0] ev [3];
    av[0] = 64'h0000_0000_FFFF_FFFF; bv[0] = 5'h01; ev[0] = 65'h0_0000_0001_0000_0000;
    av[1] = 64'h0;                   bv[1] = 5'h00; ev[1] = 65'h0;
    av[2] = 64'h8000_0000_0000_0000; bv[2] = 5'h1F; ev[2] = 65'h0_8000_0000_0000_001F;
    for (int i = 0; i < 3; i++) begin
      do_op(av[i], bv[i], lat);
      n_checks++;
      if (sum !== ev[i] || lat !== 4) begin
        n_fail++; $display("FAIL back_to_back[%0d] sum=%h lat=%0d want %h 4", i, sum, lat, ev[i]);
      end
      consume();
    end
  endtask

`ifdef SEQ_ADDER_SUB_EN
  task automatic test_sub();
    int lat;
    sub = 1'b1;
    do_op(64'd0, 5'd1, lat);
    n_checks++;
    if (sum !== 65'h0_FFFF_FFFF_FFFF_FFFF) begin
      n_fail++; $display("FAIL sub_borrow got %h want 0ffffffffffffffff", sum);
    end
    consume();
    do_op(64'd5, 5'd5, lat);
    n_checks++;
    if (sum !== 65'h1_0000_0000_0000_0000) begin
      n_fail++; $display("FAIL sub_equal got %h want 10000000000000000", sum);
    end
    consume();
    sub = 1'b0;
  endtask
`endif

  task automatic test_w32_random();
    int lat;
    int errs;
    logic [32:0] exp;
    errs = 0;
    for (int i = 0; i < 200; i++) begin
      a32 = $urandom; b32 = $urandom;
      if (i == 0) begin a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; end
      exp = {1'b0, a32} + {1'b0, b32};
      in_valid32 = 1'b1;
      @(posedge clk); #1;
      in_valid32 = 1'b0;
      lat = 0;
      while (!out_valid32 && lat < 50) begin
        @(posedge clk); #1; lat++;
      end
      n_checks++;
      if (sum32 !== exp || lat !== 4) begin
        n_fail++; errs++;
        if (errs < 10)
          $display("FAIL w32[%0d] sum=%h lat=%0d want %h 4", i, sum32, lat, exp);
      end
      out_ready32 = 1'b1;
      @(posedge clk); #1;
      out_ready32 = 1'b0;
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; sub = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    in_valid32 = 1'b0; out_ready32 = 1'b0; a32 = '0; b32 = '0;
    test_reset();
    test_full_carry();
    test_chunk_boundary();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
`ifdef SEQ_ADDER_SUB_EN
    test_sub();
`endif
    test_w32_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
